ser_shift_rx: RTL and testbench
===============================

SER_SHIFT_RX -- requirements
Module: ser_shift_rx

Interface
REQ-001 Parameter DW, default 8: serial word width in bits, range 2..32.
REQ-002 Parameter GAP_CYC, default 1000: number of clk_i cycles without a cp edge that aborts a partial word.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first received bit lands in data_o[DW-1]; 0 = first received bit lands in data_o[0].
REQ-004 clk_i  input  1  sole clock; all flops on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cp_i  input  1  serial shift clock, asynchronous to clk_i; data is taken on its rising edge.
REQ-007 dat_i  input  1  serial data, asynchronous to clk_i.
REQ-008 data_o  output  DW  last completed word.
REQ-009 valid_o  output  1  data_o holds an unconsumed word.
REQ-010 ready_i  input  1  consumer accepts data_o when valid_o=1 and ready_i=1.
REQ-011 busy_o  output  1  partial word in progress (bit count nonzero).
REQ-012 ovf_o  output  1  sticky flag: a completed word was dropped.
REQ-013 clr_i  input  1  synchronous clear of ovf_o.

Function
REQ-014 cp_i and dat_i each pass through a 2-flop synchronizer; a third flop on synced cp supplies the previous value.
REQ-015 Edge = synced cp 1 and previous cp 0; the synced dat value in that same cycle is the sampled bit.
REQ-016 Input timing contract: cp_i high and low each ≥3 clk_i cycles; dat_i stable ≥3 cycles before and 1 cycle after each cp_i rise; violations give undefined data but never lock up the block.
REQ-017 States: IDLE (bit count 0) and SHIFT (bit count 1..DW-1); busy_o = (state==SHIFT).
REQ-018 IDLE: an edge stores bit 0 and sets count=1, state SHIFT.
REQ-019 SHIFT: an edge with count<DW-1 stores the bit and increments count.
REQ-020 SHIFT: an edge with count=DW-1 completes the word; count returns to 0 and state to IDLE in the same cycle.
REQ-021 Bit placement: MSB_FIRST=1 shifts left, entering at bit 0; MSB_FIRST=0 shifts right, entering at bit DW-1.
REQ-022 Completion with holding register free (valid_o=0, or valid_o=1 and ready_i=1 in that cycle) loads data_o and sets valid_o=1.
REQ-023 Completion with valid_o=1 and ready_i=0 drops the new word; data_o is unchanged and ovf_o is set.
REQ-024 Latency: valid_o rises on the 3rd clk_i rising edge counted from the first edge that samples cp_i high for the final bit.
REQ-025 Handshake: valid_o=1 and ready_i=1 with no same-cycle completion clears valid_o on the next edge; with a same-cycle completion, valid_o stays 1 and data_o takes the new word.
REQ-026 data_o holds its value after consumption until the next load.
REQ-027 Gap counter clears on every edge and increments each cycle in SHIFT without an edge, saturating at GAP_CYC.
REQ-028 Gap counter reaching GAP_CYC returns the block to IDLE, clears count and shift register, and discards the partial word without setting ovf_o.
REQ-029 ovf_o stays 1 until clr_i=1; if clr_i and a drop coincide, the set wins.
REQ-030 Gap counter width is clog2(GAP_CYC+1); bit counter width is clog2(DW).

Reset
REQ-031 rst_n=0 immediately forces: data_o=0, valid_o=0, busy_o=0, ovf_o=0, bit count=0, gap counter=0, shift register=0, all synchronizer flops=0.
REQ-032 Reset mid-word discards the partial word; the first cp_i rise after release is bit 0 of a new word.
REQ-033 A cp_i level of 1 already present at reset release produces no edge until cp_i goes 0 and then 1.

Verification
REQ-034 DW=8, MSB_FIRST=1, ready_i=1, send 0xA5 -> data_o=0xA5, valid_o high exactly one cycle, 3 cycles after the final cp_i rise.
REQ-035 MSB_FIRST=0, send bits 1,0,1,0,0,0,0,0 in order -> data_o=0x05.
REQ-036 ready_i=0, send 0x3C then 0x81 -> data_o=0x3C, valid_o=1, ovf_o=1; pulse clr_i -> ovf_o=0 and data_o stays 0x3C.
REQ-037 Send 3 bits, idle GAP_CYC+2 cycles -> busy_o falls, ovf_o=0; then send 0xFF -> data_o=0xFF.
REQ-038 Send 5 bits, assert rst_n=0 -> all outputs 0; release and send 0x12 -> data_o=0x12.
REQ-039 Hold ready_i=1 with valid_o=1 pending and align the next completion to the accept cycle -> valid_o stays 1, data_o updates, ovf_o=0.

Source files
------------

// File: rtl/ser_shift_rx.sv
// ---------------------------------------------------------------------------
// ser_shift_rx
//
// Receives a word from a slow, externally clocked serial link (shift clock
// cp_i plus data dat_i, both asynchronous to clk_i), assembles it into a DW-bit
// word and presents it on a one-deep valid/ready holding register.
//
// Parameters
//   DW         serial word width in bits (2..32)
//   GAP_CYC    clk_i cycles without a cp_i rise that abort a partial word
//   MSB_FIRST  1: first received bit ends up in data_o[DW-1]
//              0: first received bit ends up in data_o[0]
//
// Ports
//   clk_i    in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   cp_i     in   serial shift clock; data is taken on its rising edge
//   dat_i    in   serial data
//   data_o   out  last completed word, held until the next load
//   valid_o  out  data_o holds a word not yet accepted
//   ready_i  in   consumer accepts data_o when valid_o & ready_i
//   busy_o   out  a partial word is being assembled
//   ovf_o    out  sticky: a completed word was dropped (holding reg full)
//   clr_i    in   synchronous clear of ovf_o (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module ser_shift_rx #(
    parameter int DW        = 8,
    parameter int GAP_CYC   = 1000,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          cp_i,
    input  logic          dat_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o,
    output logic          ovf_o,
    input  logic          clr_i
);

    localparam int CW = $clog2(DW);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers and rise detection
    // -----------------------------------------------------------------------
    logic       cp_s1, cp_s2, cp_prev;
    logic       dat_s1, dat_s2;
    logic [1:0] fill_q;   // shifts in 1s after reset: fill_q[1] => cp_s2 is real
    logic       armed_q;  // set once a genuine low level of cp has been seen
    logic       cp_rise;

    // NOTE: two flops per asynchronous input bound metastability; the value
    // out of the second flop is the only one any logic may look at.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cp_s1   <= 1'b0;
            cp_s2   <= 1'b0;
            cp_prev <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s2  <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            cp_s1   <= cp_i;
            cp_s2   <= cp_s1;
            cp_prev <= cp_s2;
            dat_s1  <= dat_i;
            dat_s2  <= dat_s1;
            fill_q  <= {fill_q[0], 1'b1};
            // The chain resets to 0, so a cp_i already high at release would
            // look like a rise. Only arm once the pipeline carries real input
            // and that input has been observed low.
            armed_q <= armed_q | (fill_q[1] & ~cp_s2);
        end
    end

    assign cp_rise = cp_s2 & ~cp_prev & armed_q;

    // -----------------------------------------------------------------------
    // Word assembly FSM
    // -----------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [DW-1:0] base, shifted;
    logic          gap_expired;
    logic          in_word;
    logic          complete;

    assign gap_expired = (state_q == SHIFT) && (gap_q == GW'(GAP_CYC));
    // A timed-out word is abandoned in the same cycle, so a coincident rise
    // becomes bit 0 of a fresh word rather than being lost.
    assign in_word     = (state_q == SHIFT) && !gap_expired;
    assign base        = in_word ? shreg_q : '0;
    assign shifted     = MSB_FIRST ? {base[DW-2:0], dat_s2}
                                   : {dat_s2, base[DW-1:1]};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        shreg_d  = shreg_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (cp_rise) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                    shreg_d = shifted;
                end
            end
            SHIFT: begin
                if (cp_rise) begin
                    gap_d = '0;
                    if (!in_word) begin
                        state_d = SHIFT;
                        cnt_d   = CW'(1);
                        shreg_d = shifted;
                    end else if (cnt_q == CW'(DW - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                        shreg_d  = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        shreg_d = shifted;
                    end
                end else if (gap_expired) begin
                    // Link went quiet mid-word: discard silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                    gap_d   = '0;
                    shreg_d = '0;
                end else begin
                    // gap_q < GAP_CYC here, so this saturates at GAP_CYC.
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gap_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    assign busy_o = (state_q == SHIFT);

    // -----------------------------------------------------------------------
    // Holding register and overflow flag
    // -----------------------------------------------------------------------
    logic accept;
    logic hold_free;

    assign accept    = valid_o & ready_i;
    assign hold_free = ~valid_o | ready_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            if (complete && hold_free) begin
                // Covers the accept-and-reload cycle: valid_o stays high.
                data_o  <= shifted;
                valid_o <= 1'b1;
            end else if (accept) begin
                valid_o <= 1'b0;
            end

            if (complete && !hold_free) begin
                ovf_o <= 1'b1;
            end else if (clr_i) begin
                ovf_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ser_shift_rx.sv
// ---------------------------------------------------------------------------
// tb_ser_shift_rx
//
// Directed bench for ser_shift_rx. Two instances share the serial stimulus:
// dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0, always ready). Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ser_shift_rx;

    localparam int DW  = 8;
    localparam int GAP = 1000;

    logic          clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          cp_i = 1'b0;
    logic          dat_i = 1'b0;
    logic          ready_m = 1'b0;
    logic          ready_l = 1'b1;
    logic          clr_i = 1'b0;

    logic [DW-1:0] data_m, data_l;
    logic          valid_m, valid_l;
    logic          busy_m, busy_l;
    logic          ovf_m, ovf_l;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ser_shift_rx #(.DW(DW), .GAP_CYC(GAP), .MSB_FIRST(1'b1)) dut_m (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .cp_i    (cp_i),
        .dat_i   (dat_i),
        .data_o  (data_m),
        .valid_o (valid_m),
        .ready_i (ready_m),
        .busy_o  (busy_m),
        .ovf_o   (ovf_m),
        .clr_i   (clr_i)
    );

    ser_shift_rx #(.DW(DW), .GAP_CYC(GAP), .MSB_FIRST(1'b0)) dut_l (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .cp_i    (cp_i),
        .dat_i   (dat_i),
        .data_o  (data_l),
        .valid_o (valid_l),
        .ready_i (ready_l),
        .busy_o  (busy_l),
        .ovf_o   (ovf_l),
        .clr_i   (clr_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // One serial bit: data set up 4 cycles before the rise, cp high 4 cycles.
    task automatic cp_pulse(input logic b);
        dat_i = b;
        tick(4);
        cp_i = 1'b1;
        tick(4);
        cp_i = 1'b0;
    endtask

    // Bits 7..1 of a byte, MSB first on the wire.
    task automatic send_head(input logic [7:0] w);
        for (int i = 7; i >= 1; i--) cp_pulse(w[i]);
    endtask

    task automatic send_byte(input logic [7:0] w);
        send_head(w);
        cp_pulse(w[0]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;

        // ---------------- reset state ----------------
        tick(3);
        check("rst_data",  32'(data_m), 32'h0);
        check("rst_valid", 32'(valid_m), 32'h0);
        check("rst_busy",  32'(busy_m), 32'h0);
        check("rst_ovf",   32'(ovf_m), 32'h0);
        rst_n = 1'b1;
        tick(4);

        // ---------------- 0xA5, MSB first, latency ----------------
        ready_m = 1'b1;
        w = 8'hA5;
        send_head(w);
        dat_i = w[0];
        tick(4);
        cp_i = 1'b1;
        tick(1);
        check("lat_e1_valid", 32'(valid_m), 32'h0);
        tick(1);
        check("lat_e2_valid", 32'(valid_m), 32'h0);
        tick(1);
        check("lat_e3_valid", 32'(valid_m), 32'h1);
        check("lat_e3_data",  32'(data_m), 32'hA5);
        tick(1);
        check("lat_e4_valid", 32'(valid_m), 32'h0);
        check("hold_after_accept", 32'(data_m), 32'hA5);
        tick(2);
        cp_i = 1'b0;

        // ---------------- bits 1,0,1,0,0,0,0,0 ----------------
        send_byte(8'hA0);
        check("msb_first_A0", 32'(data_m), 32'hA0);
        check("lsb_first_05", 32'(data_l), 32'h05);

        // ---------------- drop / overflow / clear ----------------
        ready_m = 1'b0;
        send_byte(8'h3C);
        check("ovf_first_valid", 32'(valid_m), 32'h1);
        check("ovf_first_data",  32'(data_m), 32'h3C);
        check("ovf_first_flag",  32'(ovf_m), 32'h0);
        send_byte(8'h81);
        check("ovf_drop_data",  32'(data_m), 32'h3C);
        check("ovf_drop_valid", 32'(valid_m), 32'h1);
        check("ovf_drop_flag",  32'(ovf_m), 32'h1);
        check("ovf_lsb_dut",    32'(ovf_l), 32'h0);
        tick(3);
        check("ovf_sticky", 32'(ovf_m), 32'h1);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("ovf_cleared",   32'(ovf_m), 32'h0);
        check("ovf_clr_data",  32'(data_m), 32'h3C);
        ready_m = 1'b1;
        tick(1);
        check("ovf_consumed", 32'(valid_m), 32'h0);

        // ---------------- completion aligned with accept ----------------
        ready_m = 1'b0;
        send_byte(8'h11);
        check("align_first_valid", 32'(valid_m), 32'h1);
        w = 8'h22;
        send_head(w);
        dat_i = w[0];
        tick(4);
        cp_i = 1'b1;
        tick(2);
        check("align_pre_data",  32'(data_m), 32'h11);
        check("align_pre_valid", 32'(valid_m), 32'h1);
        ready_m = 1'b1;
        tick(1);
        check("align_valid", 32'(valid_m), 32'h1);
        check("align_data",  32'(data_m), 32'h22);
        check("align_ovf",   32'(ovf_m), 32'h0);
        tick(1);
        check("align_drain", 32'(valid_m), 32'h0);
        tick(2);
        cp_i = 1'b0;

        // ---------------- gap timeout ----------------
        cp_pulse(1'b1);
        cp_pulse(1'b0);
        cp_pulse(1'b1);
        check("gap_busy_start", 32'(busy_m), 32'h1);
        tick(GAP - 10);
        check("gap_busy_before", 32'(busy_m), 32'h1);
        tick(12);
        check("gap_busy_after", 32'(busy_m), 32'h0);
        check("gap_ovf",        32'(ovf_m), 32'h0);
        send_byte(8'hFF);
        check("gap_next_word", 32'(data_m), 32'hFF);

        // ---------------- reset mid-word, cp high at release ----------------
        cp_pulse(1'b1);
        cp_pulse(1'b1);
        cp_pulse(1'b0);
        cp_pulse(1'b1);
        cp_pulse(1'b1);
        check("mid_busy", 32'(busy_m), 32'h1);
        @(posedge clk_i);
        #2;
        rst_n = 1'b0;
        cp_i  = 1'b1;
        #1;
        check("mid_rst_data",  32'(data_m), 32'h0);
        check("mid_rst_valid", 32'(valid_m), 32'h0);
        check("mid_rst_busy",  32'(busy_m), 32'h0);
        check("mid_rst_ovf",   32'(ovf_m), 32'h0);
        tick(3);
        rst_n = 1'b1;
        tick(8);
        check("release_high_no_edge", 32'(busy_m), 32'h0);
        cp_i = 1'b0;
        send_byte(8'h12);
        check("post_rst_word",  32'(data_m), 32'h12);
        check("post_rst_lsb",   32'(data_l), 32'h48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
